// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared types and constants for the 8x8 RGB LED matrix scanner.
//   color_t     : 2-bit cell colour as written by game logic ({red, green})
//   phase_t     : per-row scan phase produced by matrix_row_timer
//   ROWS/COLS   : matrix geometry
//   SEL_EN      : bit position of the row-enable flag inside SEL
//   OVER_EVEN/ODD : game-over checkerboard column patterns (already active-low)
//   BLANK_LEVEL : column value that turns every LED in a row off
// -----------------------------------------------------------------------------
package matrix_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'b00,
    GREEN  = 2'b01,
    RED    = 2'b10,
    YELLOW = 2'b11
  } color_t;

  typedef enum logic [1:0] {
    PH_BLANK = 2'd0,
    PH_LATCH = 2'd1,
    PH_SHOW  = 2'd2
  } phase_t;

  localparam int         ROWS        = 8;
  localparam int         COLS        = 8;
  localparam int         SEL_EN      = 3;
  localparam logic [7:0] OVER_EVEN   = 8'b01010101;
  localparam logic [7:0] OVER_ODD    = 8'b10101010;
  localparam logic [7:0] BLANK_LEVEL = 8'hFF;

  // Checkerboard pattern for a row; only the row parity matters.
  function automatic logic [7:0] overlay_row(input logic row_odd);
    return row_odd ? OVER_ODD : OVER_EVEN;
  endfunction

endpackage

// File: rtl/matrix_row_timer.sv
// -----------------------------------------------------------------------------
// matrix_row_timer
// Prescaler that slices every ROW_PERIOD = CLK_HZ/ROW_HZ clock cycles into
// BLANK (BLANK_CYCLES cycles), LATCH (1 cycle) and SHOW (the remainder).
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset (restarts in BLANK, count 0)
//   phase       out  current phase, phase_t encoding
//   row_advance out  high during the last SHOW cycle; the next edge starts a
//                    new row in BLANK
// ROW_PERIOD must exceed BLANK_CYCLES+1 and BLANK_CYCLES must be at least 1.
// -----------------------------------------------------------------------------
module matrix_row_timer
  import matrix_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int ROW_HZ       = 8_000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] phase,
  output logic       row_advance
);

  localparam int ROW_PERIOD  = CLK_HZ / ROW_HZ;
  localparam int SHOW_CYCLES = ROW_PERIOD - BLANK_CYCLES - 1;
  localparam int CNT_W       = (ROW_PERIOD > 2) ? $clog2(ROW_PERIOD) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);

  phase_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             row_advance_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PH_BLANK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    row_advance_d = 1'b0;
    case (state_q)
      PH_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = PH_LATCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PH_LATCH: begin
        state_d = PH_SHOW;
        cnt_d   = '0;
      end
      PH_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d       = PH_BLANK;
          cnt_d         = '0;
          row_advance_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = PH_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  assign phase       = state_q;
  assign row_advance = row_advance_d;

endmodule

// File: rtl/led_matrix_scanner.sv
// -----------------------------------------------------------------------------
// led_matrix_scanner
// Two-plane (red/green) 8x8 framebuffer with a cell write port, a one-row-per-
// cycle clear sweep, and a row scanner that drives the active-low matrix pins
// with per-row blanking and an optional game-over checkerboard overlay.
// Ports:
//   CLK, RST_N       clock, asynchronous active-low reset
//   wr_valid/ready   cell write handshake; ready drops during a clear
//   wr_x, wr_y       row index, column index (DATA bit y)
//   wr_color         {red, green} cell colour
//   clr              one-cycle pulse, clears the whole framebuffer
//   overlay_en       show the checkerboard instead of the framebuffer
//   DATA_R/G/B       active-low column drives (blue unused, held off)
//   SEL              {enable, row[2:0]}
//   frame_start      one-cycle pulse when row 0 is latched
// -----------------------------------------------------------------------------
module led_matrix_scanner
  import matrix_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int ROW_HZ       = 8_000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_x,
  input  logic [2:0] wr_y,
  input  logic [1:0] wr_color,
  input  logic       clr,
  input  logic       overlay_en,
  output logic [7:0] DATA_R,
  output logic [7:0] DATA_G,
  output logic [7:0] DATA_B,
  output logic [3:0] SEL,
  output logic       frame_start
);

  // ---------------------------------------------------------------------------
  // Row timing
  // ---------------------------------------------------------------------------
  logic [1:0] phase_raw;
  phase_t     phase;
  logic       row_advance;

  matrix_row_timer #(
    .CLK_HZ       (CLK_HZ),
    .ROW_HZ       (ROW_HZ),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_row_timer (
    .clk         (CLK),
    .rst_n       (RST_N),
    .phase       (phase_raw),
    .row_advance (row_advance)
  );

  assign phase = phase_t'(phase_raw);

  // ---------------------------------------------------------------------------
  // Write port and clear sweep
  // ---------------------------------------------------------------------------
  logic       clear_busy_q, clear_busy_d;
  logic [2:0] clear_row_q, clear_row_d;
  logic       clear_start;
  logic [2:0] clear_idx;
  logic       wr_fire;
  color_t     wr_col;
  logic       wr_red, wr_green;
  logic [7:0] col_mask;

  // clr wins over a write in the same cycle, hence the combinational term.
  assign wr_ready    = !clear_busy_q && !clr;
  assign wr_fire     = wr_valid && wr_ready;
  assign clear_start = clr && !clear_busy_q;
  // Row 0 is zeroed on the clr edge itself, rows 1..7 on the busy cycles.
  assign clear_idx   = clear_start ? 3'd0 : clear_row_q;

  assign wr_col   = color_t'(wr_color);
  assign wr_red   = (wr_col == RED)   || (wr_col == YELLOW);
  assign wr_green = (wr_col == GREEN) || (wr_col == YELLOW);
  assign col_mask = 8'b1 << wr_y;

  always_comb begin
    clear_busy_d = clear_busy_q;
    clear_row_d  = clear_row_q;
    if (clear_start) begin
      clear_busy_d = 1'b1;
      clear_row_d  = 3'd1;
    end else if (clear_busy_q) begin
      if (clear_row_q == 3'd7) begin
        clear_busy_d = 1'b0;
        clear_row_d  = 3'd0;
      end else begin
        clear_row_d = clear_row_q + 3'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clear_busy_q <= 1'b0;
      clear_row_q  <= 3'd0;
    end else begin
      clear_busy_q <= clear_busy_d;
      clear_row_q  <= clear_row_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Framebuffer: one bit per cell per plane, 1 = LED on
  // ---------------------------------------------------------------------------
  logic [ROWS-1:0][7:0] fb_r_q, fb_r_d;
  logic [ROWS-1:0][7:0] fb_g_q, fb_g_d;
  logic [ROWS-1:0]      row_wr;
  logic [ROWS-1:0]      row_clr;

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_fb_row
      assign row_wr[gi]  = wr_fire && (wr_x == 3'(gi));
      assign row_clr[gi] = (clear_start || clear_busy_q) && (clear_idx == 3'(gi));

      assign fb_r_d[gi] = row_clr[gi] ? 8'h00 :
                          row_wr[gi]  ? (wr_red ? (fb_r_q[gi] | col_mask)
                                                : (fb_r_q[gi] & ~col_mask))
                                      : fb_r_q[gi];
      assign fb_g_d[gi] = row_clr[gi] ? 8'h00 :
                          row_wr[gi]  ? (wr_green ? (fb_g_q[gi] | col_mask)
                                                  : (fb_g_q[gi] & ~col_mask))
                                      : fb_g_q[gi];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fb_r_q <= '0;
      fb_g_q <= '0;
    end else begin
      fb_r_q <= fb_r_d;
      fb_g_q <= fb_g_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan output registers. They only move on the LATCH edge (row data in) or
  // the edge that enters BLANK (columns dark, enable off), so a write landing
  // while a row is shown cannot tear it. The LATCH read sees pre-edge
  // framebuffer contents, so a same-cycle write waits for the next frame.
  // ---------------------------------------------------------------------------
  logic [2:0] row_q, row_d;
  logic [3:0] sel_q, sel_d;
  logic [7:0] data_r_q, data_r_d;
  logic [7:0] data_g_q, data_g_d;
  logic       frame_start_q, frame_start_d;
  logic [2:0] row_next;

  assign row_next = row_q + 3'd1;

  always_comb begin
    row_d         = row_q;
    sel_d         = sel_q;
    data_r_d      = data_r_q;
    data_g_d      = data_g_q;
    frame_start_d = 1'b0;
    if (phase == PH_LATCH) begin
      sel_d         = 4'b0000;
      sel_d[SEL_EN] = 1'b1;
      sel_d[2:0]    = row_q;
      if (overlay_en) begin
        data_r_d = overlay_row(row_q[0]);
        data_g_d = BLANK_LEVEL;
      end else begin
        data_r_d = ~fb_r_q[row_q];
        data_g_d = ~fb_g_q[row_q];
      end
      frame_start_d = (row_q == 3'd0);
    end else if (row_advance) begin
      row_d      = row_next;
      sel_d      = 4'b0000;
      sel_d[2:0] = row_next;
      data_r_d   = BLANK_LEVEL;
      data_g_d   = BLANK_LEVEL;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      row_q         <= 3'd0;
      sel_q         <= 4'b1000;
      data_r_q      <= BLANK_LEVEL;
      data_g_q      <= BLANK_LEVEL;
      frame_start_q <= 1'b0;
    end else begin
      row_q         <= row_d;
      sel_q         <= sel_d;
      data_r_q      <= data_r_d;
      data_g_q      <= data_g_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign DATA_R      = data_r_q;
  assign DATA_G      = data_g_q;
  assign DATA_B      = BLANK_LEVEL;
  assign SEL         = sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// -----------------------------------------------------------------------------
// tb_led_matrix_scanner
// Directed bench for led_matrix_scanner with ROW_PERIOD=10, BLANK_CYCLES=2.
// A cycle model of the framebuffer pushes the expected row image into a
// queue at every LATCH edge; a negedge checker pops it at the first SHOW
// cycle and also checks the dark/disabled state at the first BLANK cycle.
// -----------------------------------------------------------------------------
module tb_led_matrix_scanner;

  localparam int CLK_HZ = 1000;
  localparam int ROW_HZ = 100;
  localparam int BLANK  = 2;
  localparam int PERIOD = CLK_HZ / ROW_HZ;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_x = 3'd0;
  logic [2:0] wr_y = 3'd0;
  logic [1:0] wr_color = 2'd0;
  logic       clr = 1'b0;
  logic       overlay_en = 1'b0;
  logic [7:0] DATA_R, DATA_G, DATA_B;
  logic [3:0] SEL;
  logic       frame_start;

  always #5 clk = ~clk;

  led_matrix_scanner #(
    .CLK_HZ       (CLK_HZ),
    .ROW_HZ       (ROW_HZ),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_color    (wr_color),
    .clr         (clr),
    .overlay_en  (overlay_en),
    .DATA_R      (DATA_R),
    .DATA_G      (DATA_G),
    .DATA_B      (DATA_B),
    .SEL         (SEL),
    .frame_start (frame_start)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [2:0] row;
    logic [7:0] r;
    logic [7:0] g;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_r[8];
  logic [7:0] m_g[8];
  int         m_cnt;
  logic [2:0] m_row;
  logic       m_busy;
  logic [2:0] m_crow;
  logic       m_live;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_r[i] <= 8'h00;
        m_g[i] <= 8'h00;
      end
      m_cnt  <= 0;
      m_row  <= 3'd0;
      m_busy <= 1'b0;
      m_crow <= 3'd0;
      m_live <= 1'b0;
      exp_q.delete();
    end else begin
      m_live <= 1'b1;
      if (m_cnt == BLANK) begin
        if (overlay_en)
          exp_q.push_back({m_row, (m_row[0] ? 8'b10101010 : 8'b01010101), 8'hFF});
        else
          exp_q.push_back({m_row, ~m_r[m_row], ~m_g[m_row]});
      end
      if (m_cnt == PERIOD - 1) begin
        m_cnt <= 0;
        m_row <= m_row + 3'd1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
      if (wr_valid && !m_busy && !clr) begin
        m_r[wr_x][wr_y] <= wr_color[1];
        m_g[wr_x][wr_y] <= wr_color[0];
      end
      if (clr && !m_busy) begin
        m_r[0] <= 8'h00;
        m_g[0] <= 8'h00;
        m_busy <= 1'b1;
        m_crow <= 3'd1;
      end else if (m_busy) begin
        m_r[m_crow] <= 8'h00;
        m_g[m_crow] <= 8'h00;
        if (m_crow == 3'd7) m_busy <= 1'b0;
        m_crow <= m_crow + 3'd1;
      end
    end
  end

  exp_t e;
  always @(negedge clk) begin
    if (rst_n && m_live) begin
      if (m_cnt == BLANK + 1) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          $display("row %0d shown: SEL=%b R=%b G=%b fs=%b", e.row, SEL, DATA_R, DATA_G, frame_start);
          chk("show_sel", SEL, {1'b1, e.row});
          chk("show_r", DATA_R, e.r);
          chk("show_g", DATA_G, e.g);
          chk("show_b", DATA_B, 8'hFF);
          chk("frame_start", frame_start, (e.row == 3'd0));
        end
      end else if (m_cnt == 0) begin
        chk("blank_sel", SEL, {1'b0, m_row});
        chk("blank_r", DATA_R, 8'hFF);
        chk("blank_g", DATA_G, 8'hFF);
      end else if (m_cnt == PERIOD - 1) begin
        chk("frame_start_idle", frame_start, 1'b0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_phase(input int row, input int cnt);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m_row == 3'(row) && m_cnt == cnt) return;
    end
    chk("wait_phase_timeout", 32'd0, 32'd1);
  endtask

  // Called at a negedge: presents one write for one clock.
  task automatic do_write(input int x, input int y, input int c);
    wr_x     = 3'(x);
    wr_y     = 3'(y);
    wr_color = 2'(c);
    wr_valid = 1'b1;
    #1;
    chk("wr_ready_idle", wr_ready, 1'b1);
    $display("write x=%0d y=%0d color=%0d", x, y, c);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sel", SEL, 4'b1000);
    chk("rst_r", DATA_R, 8'hFF);
    chk("rst_g", DATA_G, 8'hFF);
    chk("rst_b", DATA_B, 8'hFF);
    chk("rst_fs", frame_start, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", wr_ready, 1'b1);
    @(negedge clk);
    chk("first_blank_sel", SEL, 4'b1000);
    chk("first_blank_r", DATA_R, 8'hFF);

    // Idle frame: dark matrix, SEL walks through every row.
    repeat (90) @(negedge clk);

    // Green cell at row 3 column 5.
    wait_phase(0, 5);
    do_write(3, 5, 1);
    wait_phase(3, 1);
    chk("row3_blank_g", DATA_G, 8'hFF);
    chk("row3_blank_en", SEL[3], 1'b0);
    wait_phase(3, 4);
    chk("row3_g", DATA_G, 8'b11011111);
    chk("row3_r", DATA_R, 8'hFF);

    // Write during row 2 SHOW must not tear the current row.
    wait_phase(2, 5);
    do_write(2, 0, 3);
    chk("tear_r", DATA_R, 8'hFF);
    chk("tear_g", DATA_G, 8'hFF);
    wait_phase(2, 4);
    chk("row2_next_r", DATA_R, 8'b11111110);
    chk("row2_next_g", DATA_G, 8'b11111110);

    // Write in the LATCH cycle of the same row shows one frame later.
    wait_phase(4, 2);
    do_write(4, 1, 2);
    wait_phase(4, 4);
    chk("latch_same_cycle_r", DATA_R, 8'hFF);
    wait_phase(4, 4);
    chk("latch_next_frame_r", DATA_R, 8'b11111101);

    // Clear with a competing write; a second clr mid-sweep is ignored.
    @(negedge clk);
    clr = 1'b1;
    wr_valid = 1'b1;
    wr_x = 3'd6;
    wr_y = 3'd6;
    wr_color = 2'd3;
    #1;
    chk("clr_ready_c1", wr_ready, 1'b0);
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      if (i == 2) begin
        clr = 1'b0;
        wr_valid = 1'b0;
      end
      clr = (i == 4);
      #1;
      chk($sformatf("clr_ready_c%0d", i), wr_ready, 1'b0);
    end
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("clr_ready_c9", wr_ready, 1'b1);
    repeat (170) @(negedge clk);
    wait_phase(6, 4);
    chk("clr_row6_r", DATA_R, 8'hFF);
    chk("clr_row6_g", DATA_G, 8'hFF);

    // Fresh content, then the overlay hides it without disturbing it.
    do_write(0, 2, 2);
    do_write(1, 7, 1);
    repeat (90) @(negedge clk);
    overlay_en = 1'b1;
    do_write(5, 3, 3);
    wait_phase(0, 4);
    chk("ovl_row0_r", DATA_R, 8'b01010101);
    chk("ovl_row0_g", DATA_G, 8'hFF);
    wait_phase(1, 4);
    chk("ovl_row1_r", DATA_R, 8'b10101010);
    repeat (80) @(negedge clk);
    overlay_en = 1'b0;
    wait_phase(0, 4);
    chk("post_ovl_row0_r", DATA_R, 8'b11111011);
    wait_phase(1, 4);
    chk("post_ovl_row1_g", DATA_G, 8'b01111111);
    wait_phase(5, 4);
    chk("post_ovl_row5_r", DATA_R, 8'b11110111);

    // Reset in the middle of a clear sweep during row 5 SHOW.
    wait_phase(5, 5);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midclr_rst_sel", SEL, 4'b1000);
    chk("midclr_rst_r", DATA_R, 8'hFF);
    chk("midclr_rst_g", DATA_G, 8'hFF);
    chk("midclr_rst_fs", frame_start, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midclr_release_ready", wr_ready, 1'b1);
    @(negedge clk);
    chk("restart_blank_sel", SEL, 4'b1000);
    chk("restart_blank_g", DATA_G, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    chk("restart_row0_fs", frame_start, 1'b1);
    repeat (90) @(negedge clk);
    wait_phase(5, 4);
    chk("restart_row5_r", DATA_R, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
